// File: rtl/jk_updown_counter_param.sv
// Parametrised up/down counter built from per-bit JK flip-flops, with enable,
// synchronous clear, clamped parallel load, wrap/saturate bounds and event pulses.
module jk_updown_counter_param #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("jk_updown_counter_param: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("jk_updown_counter_param: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_next;
  logic             force_sel;
  logic             wrap_next;
  logic             err_next;

  always_comb begin
    target    = q;
    force_sel = 1'b0;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (clr) begin
      target    = '0;
      force_sel = 1'b1;
    end else if (load) begin
      force_sel = 1'b1;
      if (64'(load_val) >= MODULUS) begin
        target   = MAXV;
        err_next = 1'b1;
      end else begin
        target = load_val;
      end
    end else if (en) begin
      if (ud) begin
        if (q == MAXV) begin
          if (!SATURATE) begin
            target    = '0;
            wrap_next = 1'b1;
          end
        end else begin
          target = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          if (!SATURATE) begin
            target    = MAXV;
            wrap_next = 1'b1;
          end
        end else begin
          target = q - 1'b1;
        end
      end
    end

    // Counting toggles exactly the bits that differ (J=K); clear/load force via J=t, K=~t.
    if (force_sel) begin
      j = target;
      k = ~target;
    end else begin
      j = q ^ target;
      k = q ^ target;
    end
    q_next = (j & ~q) | (~k & q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_next;
      wrap     <= wrap_next;
      load_err <= err_next;
    end
  end

  assign tc = en & ((ud & (q == MAXV)) | (~ud & (q == '0)));

endmodule

// File: tb/tb_jk_updown_counter_param.sv
// Bench for jk_updown_counter_param: three configurations driven in parallel and
// checked every cycle against an arithmetic model, plus directed literal checks.
module tb_jk_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, ud = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] lv = '0;
  logic [2:0] lv_c;

  logic [3:0] qa, qb;
  logic [2:0] qc;
  logic       tca, tcb, tcc, wa, wb, wc, ea, eb, ec;

  int total = 0;
  int bad   = 0;
  bit go    = 1'b0;

  // configurations: A = 4/10/wrap, B = 4/10/saturate, C = 3/8/wrap
  int mods[3]  = '{10, 10, 8};
  int sats[3]  = '{0, 1, 0};
  int spans[3] = '{16, 16, 8};
  int mq[3];
  int mw[3];
  int me[3];

  assign lv_c = lv[2:0];

  always #5 clk = ~clk;

  jk_updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .clr(clr), .load(load), .load_val(lv),
    .q(qa), .tc(tca), .wrap(wa), .load_err(ea));

  jk_updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .clr(clr), .load(load), .load_val(lv),
    .q(qb), .tc(tcb), .wrap(wb), .load_err(eb));

  jk_updown_counter_param #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .clr(clr), .load(load), .load_val(lv_c),
    .q(qc), .tc(tcc), .wrap(wc), .load_err(ec));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the action rules, one instance at a time.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        mq[i] = 0; mw[i] = 0; me[i] = 0;
      end else begin
        int v;
        v = int'(lv) % spans[i];
        mw[i] = 0;
        me[i] = 0;
        if (clr) begin
          mq[i] = 0;
        end else if (load) begin
          if (v >= mods[i]) begin
            mq[i] = mods[i] - 1;
            me[i] = 1;
          end else begin
            mq[i] = v;
          end
        end else if (en) begin
          if (ud) begin
            if (mq[i] < mods[i] - 1) mq[i] = mq[i] + 1;
            else if (sats[i] == 0) begin mq[i] = 0; mw[i] = 1; end
          end else begin
            if (mq[i] > 0) mq[i] = mq[i] - 1;
            else if (sats[i] == 0) begin mq[i] = mods[i] - 1; mw[i] = 1; end
          end
        end
      end
    end
  end

  function automatic logic exp_tc(input int i);
    return en && (ud ? (mq[i] == mods[i] - 1) : (mq[i] == 0));
  endfunction

  always @(negedge clk) begin
    if (go) begin
      check("a.q", 32'(qa), mq[0]);  check("a.wrap", 32'(wa), mw[0]);
      check("a.err", 32'(ea), me[0]); check("a.tc", 32'(tca), 32'(exp_tc(0)));
      check("b.q", 32'(qb), mq[1]);  check("b.wrap", 32'(wb), mw[1]);
      check("b.err", 32'(eb), me[1]); check("b.tc", 32'(tcb), 32'(exp_tc(1)));
      check("c.q", 32'(qc), mq[2]);  check("c.wrap", 32'(wc), mw[2]);
      check("c.err", 32'(ec), me[2]); check("c.tc", 32'(tcc), 32'(exp_tc(2)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic [3:0] v);
    clr = c; load = l; en = e; ud = u; lv = v;
  endtask

  int up_tbl[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_tbl[4]  = '{1, 0, 9, 8};
  int sat_tbl[5] = '{8, 9, 9, 9, 9};
  int alt_tbl[4] = '{4, 3, 4, 3};

  initial begin
    step();
    step();
    go = 1'b1;
    check("rst.qa", 32'(qa), 0);
    check("rst.qc", 32'(qc), 0);
    rst = 1'b1;

    // up wrap
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("up.q", 32'(qa), up_tbl[i]);
      check("up.wrap", 32'(wa), (i == 9) ? 1 : 0);
      check("up.tc", 32'(tca), (up_tbl[i] == 9) ? 1 : 0);
    end

    // down wrap from 2
    drive(0, 1, 0, 0, 4'd2);
    step();
    check("dn.load", 32'(qa), 2);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("dn.q", 32'(qa), dn_tbl[i]);
      check("dn.wrap", 32'(wa), (i == 2) ? 1 : 0);
      check("dn.tc", 32'(tca), (dn_tbl[i] == 0) ? 1 : 0);
    end

    // saturate from 7
    drive(0, 1, 0, 1, 4'd7);
    step();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("sat.q", 32'(qb), sat_tbl[i]);
      check("sat.wrap", 32'(wb), 0);
    end
    check("sat.tc", 32'(tcb), 1);
    ud = 1'b0;
    step();
    check("sat.down", 32'(qb), 8);

    // priority and load clamp
    drive(0, 1, 0, 1, 4'd5);
    step();
    check("pri.pre", 32'(qa), 5);
    drive(1, 1, 1, 1, 4'd12);
    step();
    check("pri.clr", 32'(qa), 0);
    drive(0, 1, 0, 1, 4'd12);
    step();
    check("clamp.q", 32'(qa), 9);
    check("clamp.err", 32'(ea), 1);
    lv = 4'd3;
    step();
    check("load3.q", 32'(qa), 3);
    check("load3.err", 32'(ea), 0);

    // async reset mid-count, with a pending load_err pulse visible beforehand
    drive(0, 1, 0, 1, 4'd15);
    step();
    check("ar.err_pre", 32'(ea), 1);
    drive(0, 1, 0, 1, 4'd6);
    step();
    drive(0, 0, 0, 1, 0);
    check("ar.pre", 32'(qa), 6);
    rst = 1'b0;
    #1;
    check("ar.q", 32'(qa), 0);
    check("ar.wrap", 32'(wa), 0);
    check("ar.err", 32'(ea), 0);
    en = 1'b1;
    step();
    step();
    check("ar.hold", 32'(qa), 0);
    rst = 1'b1;
    step();
    check("ar.release", 32'(qa), 1);

    // full-range rollover on C
    drive(0, 1, 0, 0, 4'd0);
    step();
    drive(0, 0, 1, 0, 0);
    step();
    check("fr.q", 32'(qc), 7);
    check("fr.wrap", 32'(wc), 1);
    drive(0, 1, 0, 0, 4'd7);
    step();
    check("fr.noerr", 32'(ec), 0);
    drive(0, 1, 0, 0, 4'd3);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i % 2 == 0), 0);
      step();
      check("fr.alt", 32'(qc), alt_tbl[i]);
    end

    // random traffic, checked by the per-cycle compare
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)));
      step();
    end

    drive(0, 0, 0, 0, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_updown_counter_param.md
Name: jk_updown_counter_param

Overview:
- Parametrised synchronous up/down counter built from per-bit JK toggle flip-flops.
- Generalises the fixed 3-bit up/down counter in several ways:
  - arbitrary width and modulus
  - count enable, synchronous clear, parallel load
  - wrap or saturate mode at the bounds
  - terminal-count and wrap-event outputs
- Used as the common counter primitive for dividers, address generators and timers.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- MODULUS, 16, number of count states; counter spans 0..MODULUS-1; legal range 2..2**WIDTH.
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- ud  input  1  direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle wrap-event pulse.
- load_err  output  1  registered one-cycle pulse flagging an out-of-range load.

Behaviour:
- Reset:
  - rst low asynchronously forces q=0, wrap=0, load_err=0, independent of clk.
  - Release is synchronous to the next rising edge; the first count may occur on the first edge after rst goes high.
- Storage: each bit is a JK flip-flop, next = (J & ~q) | (~K & q).
  - Counting uses J=K=toggle enable.
  - Clear and load drive J/K to force the bit to the target value.
- Action priority per rising edge: clr > load > en > hold.
- clr=1: q <= 0; wrap <= 0; load_err <= 0.
- load=1 (clr=0):
  - load_val < MODULUS: q <= load_val, load_err <= 0.
  - load_val >= MODULUS: q <= MODULUS-1, load_err <= 1 for one cycle.
  - wrap <= 0 in both cases.
- en=1 (clr=0, load=0), up, q < MODULUS-1: q <= q+1.
- en=1, up, q = MODULUS-1:
  - SATURATE=0: q <= 0, wrap <= 1.
  - SATURATE=1: q holds, wrap <= 0.
- en=1, down, q > 0: q <= q-1.
- en=1, down, q = 0:
  - SATURATE=0: q <= MODULUS-1, wrap <= 1.
  - SATURATE=1: q holds, wrap <= 0.
- en=0 (clr=0, load=0): q holds; wrap <= 0; load_err <= 0.
- tc = en & ((ud & q==MODULUS-1) | (~ud & q==0)).
  - tc is combinational from en, ud and q, and is valid in the same cycle.
  - tc asserts in both SATURATE modes.
- wrap and load_err are high for exactly one cycle per event. Both are visible in the cycle after the edge that caused the event, alongside the new q.
- Direction change: ud may change on any cycle and takes effect on the next edge. No dead cycle, no glitch in q.
- Latency: every q update appears one clock after the qualifying edge inputs. There is no pipelining.
- q never leaves 0..MODULUS-1 after reset, under any input sequence.
- MODULUS = 2**WIDTH:
  - Wrap follows natural binary rollover.
  - The load clamp is never triggered.
- Illegal parameters (MODULUS < 2, MODULUS > 2**WIDTH, WIDTH out of range) are rejected at elaboration.

Test Plan:
- Up wrap (WIDTH=4, MODULUS=10, SATURATE=0), rst pulse low then high, en=1, ud=1 for 12 cycles -> q = 0,1,...,9,0,1.
  - wrap high only in the cycle q=0 follows q=9.
  - tc high only while q=9.
- Down wrap (same config), load 2 then en=1, ud=0 -> q = 2,1,0,9,8.
  - wrap pulses once, with q=9.
  - tc high while q=0.
- Saturate (SATURATE=1, MODULUS=10), count up from 7 for 5 cycles -> q = 8,9,9,9,9.
  - wrap stays 0.
  - tc stays 1 while q=9.
  - Then ud=0 -> q = 8.
- Priority and clamp: at q=5 assert clr=1, load=1, en=1 together -> q=0.
  - Next cycle load=1, load_val=12 (MODULUS=10) -> q=9 and load_err=1 for one cycle.
  - Next cycle load_val=3 -> q=3 and load_err=0.
- Async reset mid-count: at q=6, drop rst between clock edges -> q=0, wrap=0, load_err=0 immediately, before the next edge.
  - Hold rst low across 2 edges -> q stays 0.
  - Release with en=1, ud=1 -> q=1 after the first edge.
- Full-range rollover (WIDTH=3, MODULUS=8): count down from 0 -> q=7 with a wrap pulse; load_val=7 never flags load_err.
  - Direction toggled every cycle from q=3 -> q alternates 4,3,4,3.
